// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- shared definitions for the extended UART transmitter.
//
// Contents:
//   PAR_NONE / PAR_EVEN / PAR_ODD  parity_mode codes (2'b11 also means none)
//   tx_state_t                     serializer FSM state encoding
//   parity_used()                  does a parity_mode code insert a parity bit
//   parity_bit()                   parity bit value for a data word and mode
//
// Configuration macro: UART_TX_PARITY_EN
//   defined   -> tx_state_t includes ST_PARITY
//   undefined -> tx_state_t has no parity state
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;
`endif

    // 2'b11 is treated as "none", so only the two explicit codes add a bit.
    function automatic logic parity_used(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Data is zero-extended to 9 bits by the caller; extra zeros do not
    // change the XOR. Odd parity is the inverse of even parity.
    function automatic logic parity_bit(input logic [8:0] data,
                                        input logic [1:0] mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_ext_if.sv
// -----------------------------------------------------------------------------
// uart_tx_ext_if -- word-side interface of the extended UART transmitter.
//
// Signals:
//   din          DBIT       data word to enqueue
//   din_valid    1          din is valid this cycle
//   din_ready    1          transmitter FIFO can accept a word (not full)
//   parity_mode  2          00 none, 01 even, 10 odd, 11 none
//   fifo_level   FIFO_AW+1  number of words currently queued
//
// Modports:
//   master  -- the word producer
//   slave   -- the transmitter
// -----------------------------------------------------------------------------
interface uart_tx_ext_if #(
    parameter int DBIT    = 8,
    parameter int FIFO_AW = 2
);
    logic [DBIT-1:0]  din;
    logic             din_valid;
    logic             din_ready;
    logic [1:0]       parity_mode;
    logic [FIFO_AW:0] fifo_level;

    modport master (
        output din, din_valid, parity_mode,
        input  din_ready, fifo_level
    );

    modport slave (
        input  din, din_valid, parity_mode,
        output din_ready, fifo_level
    );
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo -- single-clock show-ahead FIFO, depth 2**AW.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high; empties the FIFO
//   wr_en    in   write request (ignored while full)
//   wr_data  in   WIDTH  write data
//   rd_en    in   read request (ignored while empty)
//   rd_data  out  WIDTH  word at the head of the queue (valid when !empty)
//   full     out  level == depth
//   empty    out  level == 0
//   level    out  AW+1  number of stored words
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; clearing the pointers and count
    // is what empties the FIFO, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Push and pop together leave the count unchanged.
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ext.sv
// -----------------------------------------------------------------------------
// uart_tx_ext -- UART transmitter with input FIFO and optional parity bit.
//
// Frame: start (OVS ticks low), DBIT data bits LSB first (OVS ticks each),
// optional parity bit (OVS ticks), stop (SB_TICK ticks high). Words are
// popped from a sync_fifo one clk after the FSM sits in IDLE with data
// queued, so back-to-back frames are separated by exactly one IDLE clk.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-high
//   s_tick        in   oversampling tick enable, one clk wide
//   bus           slave modport of uart_tx_ext_if
//                      (din, din_valid, din_ready, parity_mode, fifo_level)
//   tx            out  serial line, idle high, registered
//   tx_busy       out  high while a frame is in start/data/parity/stop
//   tx_done_tick  out  one-clk pulse at the end of each stop period
//
// Configuration macro: UART_TX_PARITY_EN
//   defined   -> PARITY state and parity generation present
//   undefined -> parity_mode is ignored; frames never carry a parity bit
// -----------------------------------------------------------------------------
module uart_tx_ext
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16,
    parameter int FIFO_AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_tick,
    uart_tx_ext_if.slave bus,
    output logic         tx,
    output logic         tx_busy,
    output logic         tx_done_tick
);
    // One counter serves both bit periods and the stop period.
    localparam int TMAX = (SB_TICK > OVS) ? SB_TICK : OVS;
    localparam int TW   = $clog2(TMAX);
    localparam int BW   = $clog2(DBIT);

    localparam logic [TW-1:0] OVS_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

    tx_state_t       state;
    logic [TW-1:0]   tick_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [DBIT-1:0] shreg;
    logic            tx_next;

    logic [DBIT-1:0] fifo_rd_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;

`ifdef UART_TX_PARITY_EN
    logic            par_used;
    logic            par_val;
`else
    logic            unused_parity_mode;
    assign unused_parity_mode = ^bus.parity_mode;
`endif

    // -------------------------------------------------------------------------
    // Input queue
    // -------------------------------------------------------------------------
    assign fifo_pop      = (state == ST_IDLE) && !fifo_empty;
    assign bus.din_ready = !fifo_full;

    sync_fifo #(
        .WIDTH (DBIT),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.din_valid),
        .wr_data (bus.din),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (bus.fifo_level)
    );

    // -------------------------------------------------------------------------
    // Line level for the current state; registered below, so tx follows the
    // state one clk later.
    // -------------------------------------------------------------------------
    // NOTE: tx_next gets a value before the case, so every path assigns it
    // and no latch is inferred.
    always_comb begin
        tx_next = 1'b1;
        unique case (state)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next = par_val;
`endif
            default:   tx_next = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Serializer FSM with registered outputs
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments, so every branch reads the pre-edge
    // values of state, counters and shifter regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_used     <= 1'b0;
            par_val      <= 1'b0;
`endif
        end else begin
            tx           <= tx_next;
            tx_done_tick <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shreg    <= fifo_rd_data;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_busy  <= 1'b1;
                        state    <= ST_START;
`ifdef UART_TX_PARITY_EN
                        // Mode is captured here so later changes cannot
                        // alter the frame already in flight.
                        par_used <= parity_used(bus.parity_mode);
                        par_val  <= parity_bit(9'(fifo_rd_data), bus.parity_mode);
`endif
                    end
                end

                ST_START: begin
                    if (s_tick) begin
                        if (tick_cnt == OVS_LAST) begin
                            tick_cnt <= '0;
                            state    <= ST_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (s_tick) begin
                        if (tick_cnt == OVS_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= shreg >> 1;
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                                state <= par_used ? ST_PARITY : ST_STOP;
`else
                                state <= ST_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (s_tick) begin
                        if (tick_cnt == OVS_LAST) begin
                            tick_cnt <= '0;
                            state    <= ST_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
`endif

                ST_STOP: begin
                    if (s_tick) begin
                        if (tick_cnt == SB_LAST) begin
                            tick_cnt     <= '0;
                            tx_busy      <= 1'b0;
                            tx_done_tick <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ext.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ext -- directed self-checking bench for uart_tx_ext.
// DBIT=8, OVS=16, SB_TICK=16, FIFO_AW=2, s_tick high every clk.
// A line monitor records every frame (tx sampled each negedge while tx_busy
// is high); directed tests compare the recorded frames against hand-computed
// expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_ext;
    import uart_pkg::*;

    localparam int DBIT    = 8;
    localparam int OVS     = 16;
    localparam int SB_TICK = 16;
    localparam int FIFO_AW = 2;

    logic clk = 1'b0;
    logic reset;
    logic s_tick;
    logic tx;
    logic tx_busy;
    logic tx_done_tick;

    int n_checks;
    int n_fail;

    uart_tx_ext_if #(.DBIT(DBIT), .FIFO_AW(FIFO_AW)) bus ();

    uart_tx_ext #(
        .DBIT    (DBIT),
        .OVS     (OVS),
        .SB_TICK (SB_TICK),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .bus          (bus),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Frame record: line[n] is tx at the n-th negedge with tx_busy high
    // (n=0 is the first busy sample). gap counts busy-low samples before
    // the frame; *_end values are taken at the first busy-low sample.
    // ------------------------------------------------------------------
    typedef struct {
        int           len;
        int           gap;
        logic [255:0] line;
        logic         done_inside;
        logic         done_end;
        logic         tx_end;
        int           level_end;
    } frame_t;

    frame_t frames[$];

    initial begin : monitor
        frame_t cur;
        logic   in_frame;
        int     idle_run;
        in_frame = 1'b0;
        idle_run = 0;
        cur.len = 0; cur.gap = 0; cur.line = '1; cur.done_inside = 1'b0;
        cur.done_end = 1'b0; cur.tx_end = 1'b1; cur.level_end = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_frame = 1'b0;
                idle_run = 0;
            end else if (!in_frame) begin
                if (tx_busy) begin
                    in_frame        = 1'b1;
                    cur.gap         = idle_run;
                    cur.line        = '1;
                    cur.line[0]     = tx;
                    cur.done_inside = tx_done_tick;
                    cur.len         = 1;
                end else begin
                    idle_run++;
                end
            end else if (tx_busy) begin
                if (cur.len < 256) cur.line[cur.len] = tx;
                cur.done_inside = cur.done_inside | tx_done_tick;
                cur.len++;
            end else begin
                cur.done_end  = tx_done_tick;
                cur.tx_end    = tx;
                cur.level_end = int'(bus.fifo_level);
                frames.push_back(cur);
                in_frame = 1'b0;
                idle_run = 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking and helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rx_data(input frame_t f);
        logic [7:0] d;
        d = '0;
        for (int i = 0; i < DBIT; i++) d[i] = f.line[OVS*(i+1) + OVS/2];
        return d;
    endfunction

    task automatic check_frame(input string tag, input frame_t f,
                               input logic [7:0] exp_data,
                               input int has_par, input logic exp_par);
        int nbits;
        nbits = 1 + DBIT + has_par;
        check({tag, ".len"},      32'(f.len), 32'(OVS*nbits + SB_TICK));
        check({tag, ".lag"},      32'(f.line[0]), 32'(1));
        check({tag, ".start"},    32'(f.line[OVS:1]), 32'(0));
        check({tag, ".data"},     32'(rx_data(f)), 32'(exp_data));
        if (has_par != 0)
            check({tag, ".parity"}, 32'(f.line[OVS*(DBIT+1) + OVS/2]), 32'(exp_par));
        check({tag, ".stop"},     32'(f.line[OVS*nbits + OVS/2]), 32'(1));
        check({tag, ".done_end"}, 32'(f.done_end), 32'(1));
        check({tag, ".done_in"},  32'(f.done_inside), 32'(0));
    endtask

    task automatic push(input logic [7:0] d, output logic rdy);
        @(negedge clk);
        bus.din       = d;
        bus.din_valid = 1'b1;
        rdy           = bus.din_ready;
        @(posedge clk);
    endtask

    task automatic release_bus();
        @(negedge clk);
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (frames.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".frames"}, 32'(frames.size()), 32'(n));
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin : stimulus
        logic rdy;
        n_checks          = 0;
        n_fail            = 0;
        reset             = 1'b1;
        s_tick            = 1'b1;
        bus.din           = '0;
        bus.din_valid     = 1'b0;
        bus.parity_mode   = PAR_NONE;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.tx",        32'(tx), 32'(1));
        check("rst.busy",      32'(tx_busy), 32'(0));
        check("rst.done",      32'(tx_done_tick), 32'(0));
        check("rst.level",     32'(bus.fifo_level), 32'(0));
        check("rst.din_ready", 32'(bus.din_ready), 32'(1));
        reset = 1'b0;

        // 0x55, no parity: 160 clk frame, bits 1,0,1,0,...
        frames.delete();
        push(8'h55, rdy);
        check("t55.ready", 32'(rdy), 32'(1));
        release_bus();
        wait_frames("t55", 1, 400);
        if (frames.size() > 0) begin
            check_frame("t55", frames[0], 8'h55, 0, 1'b0);
            check("t55.level_end", 32'(frames[0].level_end), 32'(0));
        end
        repeat (20) @(negedge clk);
        check("t55.idle_tx",   32'(tx), 32'(1));
        check("t55.idle_done", 32'(tx_done_tick), 32'(0));

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones: even parity bit 1, odd parity bit 0
        frames.delete();
        bus.parity_mode = PAR_EVEN;
        push(8'h07, rdy);
        release_bus();
        wait_frames("even", 1, 400);
        if (frames.size() > 0) check_frame("even", frames[0], 8'h07, 1, 1'b1);

        frames.delete();
        bus.parity_mode = PAR_ODD;
        push(8'h07, rdy);
        release_bus();
        wait_frames("odd", 1, 400);
        if (frames.size() > 0) check_frame("odd", frames[0], 8'h07, 1, 1'b0);

        // Mode change mid-frame must not affect the frame in flight
        frames.delete();
        bus.parity_mode = PAR_EVEN;
        push(8'h07, rdy);
        release_bus();
        repeat (20) @(negedge clk);
        bus.parity_mode = PAR_ODD;
        wait_frames("midmode", 1, 400);
        if (frames.size() > 0) check_frame("midmode", frames[0], 8'h07, 1, 1'b1);
        bus.parity_mode = PAR_NONE;
`else
        // Parity disabled in the build: modes 01/10 still give no parity bit
        frames.delete();
        bus.parity_mode = PAR_EVEN;
        push(8'h07, rdy);
        release_bus();
        wait_frames("nopar_even", 1, 400);
        if (frames.size() > 0) check_frame("nopar_even", frames[0], 8'h07, 0, 1'b0);

        frames.delete();
        bus.parity_mode = PAR_ODD;
        push(8'hC3, rdy);
        release_bus();
        wait_frames("nopar_odd", 1, 400);
        if (frames.size() > 0) check_frame("nopar_odd", frames[0], 8'hC3, 0, 1'b0);
        bus.parity_mode = PAR_NONE;
`endif

        // Six words back-to-back into a depth-4 FIFO: word 6 is refused
        frames.delete();
        for (int i = 0; i < 6; i++) begin
            push(8'h11 + 8'(i), rdy);
            check($sformatf("fill.ready%0d", i), 32'(rdy), 32'(i < 5));
        end
        release_bus();
        check("fill.level",     32'(bus.fifo_level), 32'(4));
        check("fill.din_ready", 32'(bus.din_ready), 32'(0));
        wait_frames("fill", 5, 1200);
        for (int j = 0; j < frames.size(); j++) begin
            check($sformatf("fill.data%0d", j),  32'(rx_data(frames[j])), 32'(8'h11 + 8'(j)));
            check($sformatf("fill.level%0d", j), 32'(frames[j].level_end), 32'(4 - j));
            if (j > 0) check($sformatf("fill.gap%0d", j), 32'(frames[j].gap), 32'(1));
        end
        repeat (300) @(negedge clk);
        check("fill.no_word6", 32'(frames.size()), 32'(5));

        // Three queued words: contiguous frames, level steps 2,1,0
        frames.delete();
        push(8'hA5, rdy);
        push(8'h3C, rdy);
        push(8'hF0, rdy);
        release_bus();
        wait_frames("three", 3, 800);
        for (int j = 0; j < frames.size(); j++) begin
            check($sformatf("three.level%0d", j), 32'(frames[j].level_end), 32'(2 - j));
            if (j > 0) check($sformatf("three.gap%0d", j), 32'(frames[j].gap), 32'(1));
        end
        if (frames.size() > 2) check_frame("three.f2", frames[2], 8'hF0, 0, 1'b0);

        // Reset during data bit 3 with two words queued
        frames.delete();
        push(8'h00, rdy);
        push(8'h81, rdy);
        push(8'h42, rdy);
        release_bus();
        repeat (70) @(negedge clk);
        check("rstmid.pre_busy",  32'(tx_busy), 32'(1));
        check("rstmid.pre_level", 32'(bus.fifo_level), 32'(2));
        check("rstmid.pre_tx",    32'(tx), 32'(0));
        #2 reset = 1'b1;
        #1;
        check("rstmid.tx",        32'(tx), 32'(1));
        check("rstmid.busy",      32'(tx_busy), 32'(0));
        check("rstmid.level",     32'(bus.fifo_level), 32'(0));
        check("rstmid.din_ready", 32'(bus.din_ready), 32'(1));
        @(negedge clk);
        reset = 1'b0;
        begin
            int low_cnt;
            int busy_cnt;
            low_cnt  = 0;
            busy_cnt = 0;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                if (tx !== 1'b1) low_cnt++;
                if (tx_busy !== 1'b0) busy_cnt++;
            end
            check("rstmid.tx_low_after",  32'(low_cnt), 32'(0));
            check("rstmid.busy_after",    32'(busy_cnt), 32'(0));
            check("rstmid.frames_after",  32'(frames.size()), 32'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
